// File: rtl/matmul_tile_sched.sv
`timescale 1ns/1ps
// Tile scheduler for the 4x4 systolic matmul: walks (p,q,r) block triples with r innermost,
// issues one feed command per triple and one writeback per finished (p,q) block.
module matmul_tile_sched #(
   parameter int unsigned M = 16,
   parameter int unsigned K = 16,
   parameter int unsigned N = 16,
   localparam int unsigned PB = M / 4,
   localparam int unsigned QB = N / 4,
   localparam int unsigned RB = K / 4,
   localparam int unsigned PW = (PB > 1) ? $clog2(PB) : 1,
   localparam int unsigned QW = (QB > 1) ? $clog2(QB) : 1,
   localparam int unsigned RW = (RB > 1) ? $clog2(RB) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_abort,
   output logic          o_cmd_valid,
   input  logic          i_cmd_ready,
   output logic [PW-1:0] o_cmd_p,
   output logic [QW-1:0] o_cmd_q,
   output logic [RW-1:0] o_cmd_r,
   output logic          o_cmd_first,
   output logic          o_cmd_last,
   input  logic          i_blk_done,
   output logic          o_wb_valid,
   input  logic          i_wb_ready,
   output logic [PW-1:0] o_wb_p,
   output logic [QW-1:0] o_wb_q,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err_spurious
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_WB    = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_p;
   logic [QW-1:0] r_q;
   logic [RW-1:0] r_r;
   logic          r_err;
   logic          r_cmd_valid;
   logic          r_wb_valid;
   logic          r_busy;
   logic          r_done;
   logic          r_cmd_first;
   logic          r_cmd_last;

   state_t        w_nxt_state;
   logic [PW-1:0] w_nxt_p;
   logic [QW-1:0] w_nxt_q;
   logic [RW-1:0] w_nxt_r;
   logic          w_nxt_err;
   logic          w_p_last;
   logic          w_q_last;
   logic          w_r_last;

   assign w_p_last = (r_p == PW'(PB - 1));
   assign w_q_last = (r_q == QW'(QB - 1));
   assign w_r_last = (r_r == RW'(RB - 1));

   // Next-state and index sequencing; abort overrides everything except reset.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_p     = r_p;
      w_nxt_q     = r_q;
      w_nxt_r     = r_r;
      w_nxt_err   = r_err;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_nxt_state = S_ISSUE;
               w_nxt_err   = 1'b0;
            end
         end
         S_ISSUE: begin
            if (i_cmd_ready) begin
               w_nxt_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_blk_done) begin
               if (w_r_last) begin
                  w_nxt_state = S_WB;
               end else begin
                  w_nxt_r     = r_r + RW'(1);
                  w_nxt_state = S_ISSUE;
               end
            end
         end
         S_WB: begin
            if (i_wb_ready) begin
               w_nxt_r = '0;
               if (w_q_last) begin
                  w_nxt_q = '0;
                  w_nxt_p = w_p_last ? '0 : r_p + PW'(1);
               end else begin
                  w_nxt_q = r_q + QW'(1);
               end
               w_nxt_state = (w_p_last && w_q_last) ? S_FIN : S_ISSUE;
            end
         end
         S_FIN: begin
            w_nxt_state = S_IDLE;
            w_nxt_p     = '0;
            w_nxt_q     = '0;
            w_nxt_r     = '0;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_p     = '0;
            w_nxt_q     = '0;
            w_nxt_r     = '0;
         end
      endcase
      if (i_blk_done && (r_state != S_WAIT)) begin
         w_nxt_err = 1'b1;
      end
      if (i_abort) begin
         w_nxt_state = S_IDLE;
         w_nxt_p     = '0;
         w_nxt_q     = '0;
         w_nxt_r     = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_p     <= w_nxt_p;
         r_q     <= w_nxt_q;
         r_r     <= w_nxt_r;
         r_err   <= w_nxt_err;
      end
   end

   // Outputs are registered from the next state so no input reaches a port combinationally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cmd_valid <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cmd_first <= 1'b1;
         r_cmd_last  <= (RB == 1);
      end else begin
         r_cmd_valid <= (w_nxt_state == S_ISSUE);
         r_wb_valid  <= (w_nxt_state == S_WB);
         r_busy      <= (w_nxt_state != S_IDLE);
         r_done      <= (w_nxt_state == S_FIN);
         r_cmd_first <= (w_nxt_r == '0);
         r_cmd_last  <= (w_nxt_r == RW'(RB - 1));
      end
   end

   assign o_cmd_valid    = r_cmd_valid;
   assign o_cmd_p        = r_p;
   assign o_cmd_q        = r_q;
   assign o_cmd_r        = r_r;
   assign o_cmd_first    = r_cmd_first;
   assign o_cmd_last     = r_cmd_last;
   assign o_wb_valid     = r_wb_valid;
   assign o_wb_p         = r_p;
   assign o_wb_q         = r_q;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err_spurious = r_err;

endmodule
